load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory stage downstream of the decoder. Executes the load/store selected by the 3-bit memCtrl code on the ALU address.
//  Issues one request to the data memory over a req/ack handshake, with byte enables and lane-replicated store data.
//  Returns sign- or zero-extended load data for writeback. Holds lsuBusy high to stall the pipeline while an access is open.
// PARAMETERS
//  XLEN     32  data/address width (only 32 supported)
//  TIMEOUT  16  cycles in ACCESS without dmemAck before the access is aborted with lsuErr
// PORTS
//  clk        in   1     clock; all state updates on rising edge
//  rst        in   1     reset, asynchronous, active-high
//  lsValid    in   1     memory op present this cycle; memCtrl/addr/storeData sampled only when high
//  memCtrl    in   3     000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW
//  addr       in   XLEN  byte address (ALU result)
//  storeData  in   XLEN  rs2 value; low byte/half used for SB/SH
//  lsuBusy    out  1     state != IDLE (combinational); upstream stalls while high
//  lsuDone    out  1     1-cycle pulse: op complete (success or error)
//  lsuErr     out  1     valid with lsuDone: misaligned or timeout
//  loadData   out  XLEN  extended load result, valid from lsuDone until next load completes
//  dmemReq    out  1     request, registered, held until ack
//  dmemWe     out  1     1 = store
//  dmemAddr   out  XLEN  {addr[31:2],2'b00}
//  dmemBe     out  4     byte enables
//  dmemWdata  out  XLEN  lane-replicated store data
//  dmemAck    in   1     memory completion, 1 cycle; rdata valid same cycle
//  dmemRdata  in   XLEN  read word
// BEHAVIOUR
//  Reset (asserted at any time, incl. mid-access): state=IDLE; every output 0; timeout counter 0; dmemReq drops immediately.
//  FSM IDLE -> ACCESS -> RESP -> IDLE. lsValid is sampled only in IDLE; it is ignored while lsuBusy=1.
//  IDLE, aligned op: latch op/addr/data; next cycle enter ACCESS with dmemReq=1.
//  IDLE, misaligned op (LH/LHU/SH with addr[0]; LW/SW with addr[1:0]!=0): no memory request; go to RESP with lsuErr=1.
//  ACCESS: dmemReq/We/Addr/Be/Wdata stay stable until ack.
//   On dmemAck: loads capture the extracted dmemRdata into loadData; go to RESP, dmemReq=0.
//   Counter increments each ACCESS cycle without ack. At TIMEOUT, abort to RESP with lsuErr=1; loadData unchanged.
//  RESP: lsuDone=1 for exactly one cycle, then IDLE. lsuErr is 0 whenever lsuDone=0.
//  Minimum latency (ack in first ACCESS cycle): lsValid@T0 -> dmemReq@T1, ack@T1 -> lsuDone@T2.
//   lsuBusy is high T1..T2; a new op is accepted at T3.
//  dmemAck outside ACCESS (incl. a late ack after reset or timeout) is ignored.
//  Byte enables, o = addr[1:0]: B: 4'b0001<<o; H: o[1] ? 1100 : 0011; W: 1111. Loads drive the same Be, dmemWe=0.
//  dmemWdata: SB {4{sd[7:0]}}; SH {2{sd[15:0]}}; SW sd.
//  Load extract: byte = rdata[8*o +: 8], half = rdata[16*o[1] +: 16].
//   LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
//  Stores never modify loadData.
// STRUCTURE
//  Package fyra_pkg:
//   - memCtrl localparams MEM_LB..MEM_SW (codes above), shared with the decoder;
//   - typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t.
//  Sub-module lsu_lane_align (combinational): memCtrl + addr[1:0] + data -> be, wdata, extended load, misaligned flag.
//  Top module holds the FSM, operand latches, timeout counter, and the loadData register.
// TESTING
//  LB addr=0x103, rdata=0x80FF_0000, ack@T1 -> dmemBe=1000, loadData=0xFFFF_FF80, lsuDone@T2, lsuErr=0.
//  LHU addr=0x202, rdata=0xBEEF_1234 -> Be=1100, loadData=0x0000_BEEF. Same case with LH -> 0xFFFF_BEEF.
//  SH addr=0x6, sd=0xAAAA_5678 -> dmemWe=1, Be=1100, dmemAddr=0x4, Wdata=0x5678_5678; loadData unchanged.
//  LW addr=0x2 -> no dmemReq; lsuDone+lsuErr one cycle after lsValid. SH addr=0x1 -> same.
//  SW with ack held low -> dmemReq stable for 16 cycles, then drops; lsuDone+lsuErr. Late ack ignored; next op succeeds.
//  rst asserted mid-ACCESS -> dmemReq/lsuBusy 0 same cycle (async). Ack after release ignored. New LW completes normally.

Source files
------------

// File: rtl/fyra_pkg.sv
// Shared definitions for the memory stage.
//  - memCtrl operation codes, shared with the decoder
//  - load/store unit state encoding
//  - small helpers that classify a memCtrl code
package fyra_pkg;

    localparam logic [2:0] MEM_LB  = 3'b000;
    localparam logic [2:0] MEM_LH  = 3'b001;
    localparam logic [2:0] MEM_LW  = 3'b010;
    localparam logic [2:0] MEM_LBU = 3'b011;
    localparam logic [2:0] MEM_LHU = 3'b100;
    localparam logic [2:0] MEM_SB  = 3'b101;
    localparam logic [2:0] MEM_SH  = 3'b110;
    localparam logic [2:0] MEM_SW  = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    // All load codes sit below the store codes.
    function automatic logic is_load(input logic [2:0] ctrl);
        return (ctrl <= MEM_LHU);
    endfunction

    function automatic logic is_store(input logic [2:0] ctrl);
        return (ctrl > MEM_LHU);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the load/store unit.
// Ports:
//  i_mem_ctrl    memCtrl code of the operation
//  i_offset      byte offset within the word (addr[1:0])
//  i_store_data  rs2 value to be written
//  i_rdata       word returned by the data memory
//  o_be          byte enables for the access
//  o_wdata       store data replicated across all lanes
//  o_load_data   selected lane, sign- or zero-extended
//  o_misaligned  access does not fit its natural alignment
module lsu_lane_align
    import fyra_pkg::*;
(
    input  logic [2:0]  i_mem_ctrl,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data,
    output logic        o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_offset, 3'b000} +: 8];
    assign w_half = i_rdata[{i_offset[1], 4'b0000} +: 16];

    always_comb begin
        o_be         = 4'b0000;
        o_wdata      = 32'h0;
        o_load_data  = 32'h0;
        o_misaligned = 1'b0;
        case (i_mem_ctrl)
            MEM_LB, MEM_LBU, MEM_SB: begin
                o_be    = 4'b0001 << i_offset;
                o_wdata = {4{i_store_data[7:0]}};
                if (i_mem_ctrl == MEM_LB) begin
                    o_load_data = {{24{w_byte[7]}}, w_byte};
                end else begin
                    o_load_data = {24'h0, w_byte};
                end
            end
            MEM_LH, MEM_LHU, MEM_SH: begin
                o_be         = i_offset[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_store_data[15:0]}};
                o_misaligned = i_offset[0];
                if (i_mem_ctrl == MEM_LH) begin
                    o_load_data = {{16{w_half[15]}}, w_half};
                end else begin
                    o_load_data = {16'h0, w_half};
                end
            end
            default: begin
                // MEM_LW, MEM_SW
                o_be         = 4'b1111;
                o_wdata      = i_store_data;
                o_load_data  = i_rdata;
                o_misaligned = (i_offset != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: executes one load or store per accepted lsValid over a
// req/ack data-memory handshake.
// Handshake: dmemReq is raised the cycle after acceptance and held, with
// dmemWe/Addr/Be/Wdata stable, until a cycle in which dmemAck is high
// (rdata valid in that same cycle) or until the timeout aborts the access.
// dmemAck is honoured only in ACCESS.
// Ports:
//  clk, rst                 clock, async active-high reset
//  lsValid/memCtrl/addr/
//  storeData                operation request, sampled only in IDLE
//  lsuBusy                  state != IDLE, stalls upstream
//  lsuDone/lsuErr           one-cycle completion pulse and error flag
//  loadData                 last successful load result
//  dmemReq/We/Addr/Be/Wdata data memory request
//  dmemAck/dmemRdata        data memory response
//  dbgState                 current FSM state for observation
module load_store_unit
    import fyra_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lsValid,
    input  logic [2:0]      memCtrl,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] storeData,
    output logic            lsuBusy,
    output logic            lsuDone,
    output logic            lsuErr,
    output logic [XLEN-1:0] loadData,
    output logic            dmemReq,
    output logic            dmemWe,
    output logic [XLEN-1:0] dmemAddr,
    output logic [3:0]      dmemBe,
    output logic [XLEN-1:0] dmemWdata,
    input  logic            dmemAck,
    input  logic [XLEN-1:0] dmemRdata,
    output logic [1:0]      dbgState
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_t       r_state;
    logic [2:0]       r_ctrl;
    logic [1:0]       r_off;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic             r_err;
    logic [XLEN-1:0]  r_load;
    logic             r_req;
    logic             r_we;
    logic [XLEN-1:0]  r_addr;
    logic [3:0]       r_be;
    logic [XLEN-1:0]  r_wdata;

    logic [2:0]       w_ctrl;
    logic [1:0]       w_off;
    logic [3:0]       w_be;
    logic [XLEN-1:0]  w_wdata;
    logic [XLEN-1:0]  w_load;
    logic             w_mis;

    // One aligner serves both phases: in IDLE it steers the incoming
    // operation, afterwards it extracts load data for the latched one.
    assign w_ctrl = (r_state == IDLE) ? memCtrl   : r_ctrl;
    assign w_off  = (r_state == IDLE) ? addr[1:0] : r_off;

    lsu_lane_align u_align (
        .i_mem_ctrl   (w_ctrl),
        .i_offset     (w_off),
        .i_store_data (storeData),
        .i_rdata      (dmemRdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load),
        .o_misaligned (w_mis)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ctrl  <= 3'b000;
            r_off   <= 2'b00;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_load  <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= 4'b0000;
            r_wdata <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (lsValid) begin
                        r_ctrl <= memCtrl;
                        r_off  <= addr[1:0];
                        r_cnt  <= '0;
                        if (w_mis) begin
                            // Misaligned: report straight away, no memory traffic.
                            r_state <= RESP;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= ACCESS;
                            r_req   <= 1'b1;
                            r_we    <= is_store(memCtrl);
                            r_addr  <= {addr[XLEN-1:2], 2'b00};
                            r_be    <= w_be;
                            r_wdata <= w_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (dmemAck) begin
                        r_state <= RESP;
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        if (is_load(r_ctrl)) begin
                            r_load <= w_load;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        // TIMEOUT-th cycle without ack: abort.
                        r_state <= RESP;
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign lsuBusy   = (r_state != IDLE);
    assign lsuDone   = r_done;
    assign lsuErr    = r_err;
    assign loadData  = r_load;
    assign dmemReq   = r_req;
    assign dmemWe    = r_we;
    assign dmemAddr  = r_addr;
    assign dmemBe    = r_be;
    assign dmemWdata = r_wdata;
    assign dbgState  = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic        lsValid;
  logic [2:0]  memCtrl;
  logic [31:0] addr;
  logic [31:0] storeData;
  logic        lsuBusy;
  logic        lsuDone;
  logic        lsuErr;
  logic [31:0] loadData;
  logic        dmemReq;
  logic        dmemWe;
  logic [31:0] dmemAddr;
  logic [3:0]  dmemBe;
  logic [31:0] dmemWdata;
  logic        dmemAck;
  logic [31:0] dmemRdata;
  logic [1:0]  dbgState;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_load;

  load_store_unit #(.XLEN(32), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .lsValid   (lsValid),
    .memCtrl   (memCtrl),
    .addr      (addr),
    .storeData (storeData),
    .lsuBusy   (lsuBusy),
    .lsuDone   (lsuDone),
    .lsuErr    (lsuErr),
    .loadData  (loadData),
    .dmemReq   (dmemReq),
    .dmemWe    (dmemWe),
    .dmemAddr  (dmemAddr),
    .dmemBe    (dmemBe),
    .dmemWdata (dmemWdata),
    .dmemAck   (dmemAck),
    .dmemRdata (dmemRdata),
    .dbgState  (dbgState)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [2:0] c);
    case (c)
      3'd0, 3'd3, 3'd5: return 1;
      3'd1, 3'd4, 3'd6: return 2;
      default:          return 4;
    endcase
  endfunction

  function automatic bit op_is_store(input logic [2:0] c);
    return c >= 3'd5;
  endfunction

  function automatic bit ref_mis(input logic [2:0] c, input logic [31:0] a);
    return (a % op_size(c)) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] c, input logic [31:0] a);
    int o;
    o = a % 4;
    case (op_size(c))
      1:       return 4'(1 << o);
      2:       return (o >= 2) ? 4'd12 : 4'd3;
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] c, input logic [31:0] sd);
    case (op_size(c))
      1:       return (sd % 256) * 32'h0101_0101;
      2:       return (sd % 65536) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] c, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    int o;
    o = a % 4;
    case (op_size(c))
      1: begin
        v = (rd >> (8 * o)) % 256;
        if (c == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
      end
      2: begin
        v = (rd >> (16 * (o / 2))) % 65536;
        if (c == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  // ---------------- driver ----------------
  // delay >= 0: ack in that ACCESS cycle (0 = first); delay < 0: never ack.
  task automatic do_op(input string tag, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rd, input int delay);
    bit mis;
    int cyc;
    logic [31:0] e;
    mis = ref_mis(c, a);
    if (!mis && delay >= 0 && !op_is_store(c)) e = ref_load(c, a, rd);
    else e = exp_load;
    exp_q.push_back(e);

    @(negedge clk);
    check_eq({tag, "_idle_busy"}, 32'(lsuBusy), 32'd0);
    lsValid = 1'b1; memCtrl = c; addr = a; storeData = sd;
    @(negedge clk);
    // Inputs during busy must be ignored.
    lsValid = 1'($urandom); memCtrl = 3'($urandom); addr = $urandom; storeData = $urandom;
    if (mis) begin
      check_eq({tag, "_mis_done"}, 32'(lsuDone), 32'd1);
      check_eq({tag, "_mis_err"}, 32'(lsuErr), 32'd1);
      check_eq({tag, "_mis_req"}, 32'(dmemReq), 32'd0);
    end else begin
      cyc = 0;
      while (!lsuDone && cyc < 40) begin
        check_eq({tag, "_req"}, 32'(dmemReq), 32'd1);
        check_eq({tag, "_we"}, 32'(dmemWe), 32'(op_is_store(c)));
        check_eq({tag, "_addr"}, dmemAddr, a - (a % 4));
        check_eq({tag, "_be"}, 32'(dmemBe), 32'(ref_be(c, a)));
        if (op_is_store(c)) check_eq({tag, "_wdata"}, dmemWdata, ref_wdata(c, sd));
        if (delay >= 0 && cyc == delay) begin
          dmemAck = 1'b1; dmemRdata = rd;
        end else begin
          dmemRdata = $urandom;
        end
        @(negedge clk);
        dmemAck = 1'b0;
        cyc++;
      end
      check_eq({tag, "_latency"}, 32'(cyc), (delay >= 0) ? 32'(delay + 1) : 32'(TIMEOUT));
      check_eq({tag, "_done"}, 32'(lsuDone), 32'd1);
      check_eq({tag, "_err"}, 32'(lsuErr), (delay >= 0) ? 32'd0 : 32'd1);
      check_eq({tag, "_req_drop"}, 32'(dmemReq), 32'd0);
    end
    exp_load = exp_q.pop_front();
    check_eq({tag, "_load"}, loadData, exp_load);
    @(negedge clk);
    lsValid = 1'b0;
    check_eq({tag, "_done_pulse"}, 32'(lsuDone), 32'd0);
    check_eq({tag, "_err_low"}, 32'(lsuErr), 32'd0);
    check_eq({tag, "_busy_end"}, 32'(lsuBusy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(lsuBusy), 32'd0);
    check_eq({tag, "_done"}, 32'(lsuDone), 32'd0);
    check_eq({tag, "_err"}, 32'(lsuErr), 32'd0);
    check_eq({tag, "_load"}, loadData, 32'd0);
    check_eq({tag, "_req"}, 32'(dmemReq), 32'd0);
    check_eq({tag, "_we"}, 32'(dmemWe), 32'd0);
    check_eq({tag, "_daddr"}, dmemAddr, 32'd0);
    check_eq({tag, "_be"}, 32'(dmemBe), 32'd0);
    check_eq({tag, "_wdata"}, dmemWdata, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  c;
    logic [31:0] a;
    int d;

    rst = 1'b1; lsValid = 1'b0; memCtrl = 3'd0; addr = 32'd0; storeData = 32'd0;
    dmemAck = 1'b0; dmemRdata = 32'd0;
    exp_load = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Directed cases.
    do_op("lb",  3'd0, 32'h0000_0103, 32'h0,         32'h80FF_0000, 0);
    do_op("lhu", 3'd4, 32'h0000_0202, 32'h0,         32'hBEEF_1234, 1);
    do_op("lh",  3'd1, 32'h0000_0202, 32'h0,         32'hBEEF_1234, 2);
    do_op("sh",  3'd6, 32'h0000_0006, 32'hAAAA_5678, 32'h1234_5678, 0);
    do_op("lw_mis", 3'd2, 32'h0000_0002, 32'h0,      32'h0,         0);
    do_op("sh_mis", 3'd6, 32'h0000_0001, 32'h1234,   32'h0,         0);
    do_op("sb",  3'd5, 32'h0000_0011, 32'h0000_00C3, 32'h0,         3);
    do_op("sw_to", 3'd7, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0,       -1);

    // Late ack after the timeout must be ignored.
    dmemAck = 1'b1; dmemRdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmemAck = 1'b0;
    check_eq("late_ack_done", 32'(lsuDone), 32'd0);
    check_eq("late_ack_busy", 32'(lsuBusy), 32'd0);
    check_eq("late_ack_load", loadData, exp_load);
    do_op("lw_after_to", 3'd2, 32'h0000_0080, 32'h0, 32'h0123_4567, 0);

    // Reset in the middle of an access.
    @(negedge clk);
    lsValid = 1'b1; memCtrl = 3'd2; addr = 32'h0000_0100;
    @(negedge clk);
    lsValid = 1'b0;
    check_eq("mid_req_before", 32'(dmemReq), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_req", 32'(dmemReq), 32'd0);
    check_eq("mid_rst_busy", 32'(lsuBusy), 32'd0);
    exp_load = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    dmemAck = 1'b1; dmemRdata = 32'hCAFE_F00D;
    @(negedge clk);
    dmemAck = 1'b0;
    check_eq("post_rst_ack_busy", 32'(lsuBusy), 32'd0);
    check_eq("post_rst_ack_done", 32'(lsuDone), 32'd0);
    check_eq("post_rst_ack_load", loadData, 32'd0);
    do_op("lw_post_rst", 3'd2, 32'h0000_0104, 32'h0, 32'h89AB_CDEF, 1);

    // Randomized operations.
    for (int i = 0; i < 80; i++) begin
      c = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a - (a % op_size(c));
      d = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 4));
      do_op("rand", c, a, $urandom, $urandom, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
